// File: rtl/config_loader_pkg.sv
// Shared definitions for the configuration latch write path: loader states,
// default bus/frame sizes shared with the latch bank, and a width helper.
package config_loader_pkg;

    localparam int DEFAULT_DATA_W    = 32;
    localparam int DEFAULT_NUM_WORDS = 10;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_WORD,
        SETUP,
        STROBE,
        HOLD,
        DONE
    } loader_state_e;

    // Never returns less than 1 so degenerate sizes still yield a legal vector.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/cfg_phase_timer.sv
// Loadable down-counter that times the setup, strobe and hold phases.
// The counter stops at zero and raises zero_o while it sits there.
module cfg_phase_timer #(
    parameter int CNT_W = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/config_word_loader.sv
// Write-side controller for the configuration latch bank: accepts a frame of
// words and strobes one registered, one-hot latch enable per word.
module config_word_loader
    import config_loader_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int NUM_WORDS = DEFAULT_NUM_WORDS,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 1,
    parameter int HOLD_CYC  = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         io_start,
    input  logic                         io_abort,
    input  logic                         io_in_valid,
    input  logic [DATA_W-1:0]            io_in_data,
    output logic                         io_in_ready,
    output logic [DATA_W-1:0]            io_d_out,
    output logic [NUM_WORDS-1:0]         io_configs_en,
    output logic [clog2(NUM_WORDS)-1:0]  io_word_idx,
    output logic                         io_busy,
    output logic                         io_done
);

    localparam int IDX_W   = clog2(NUM_WORDS);
    localparam int MAX_CYC = (SETUP_CYC > PULSE_CYC)
                           ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                           : ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
    localparam int CNT_W   = clog2(MAX_CYC + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    loader_state_e        state_q, state_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic [NUM_WORDS-1:0] en_q, en_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 tmr_load;
    logic [CNT_W-1:0]     tmr_val;
    logic                 tmr_zero;

    cfg_phase_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .load_i    (tmr_load),
        .load_val_i(tmr_val),
        .zero_o    (tmr_zero)
    );

    // Every output is computed one cycle ahead so it can be driven straight from a flop.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        en_d     = '0;
        idx_d    = idx_q;
        ready_d  = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;

        case (state_q)
            IDLE: begin
                if (io_start && !io_abort) begin
                    state_d = WAIT_WORD;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    ready_d = 1'b1;
                end
            end
            WAIT_WORD: begin
                ready_d = 1'b1;
                if (io_in_valid && ready_q) begin
                    data_d   = io_in_data;
                    state_d  = SETUP;
                    ready_d  = 1'b0;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(SETUP_CYC - 1);
                end
            end
            SETUP: begin
                if (tmr_zero) begin
                    state_d  = STROBE;
                    en_d     = NUM_WORDS'(1) << idx_q;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(PULSE_CYC - 1);
                end
            end
            STROBE: begin
                en_d = en_q;
                if (tmr_zero) begin
                    state_d  = HOLD;
                    en_d     = '0;
                    tmr_load = 1'b1;
                    tmr_val  = CNT_W'(HOLD_CYC - 1);
                end
            end
            HOLD: begin
                if (tmr_zero) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = WAIT_WORD;
                        idx_d   = idx_q + IDX_W'(1);
                        ready_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                idx_d   = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides whatever the current state decided; the data bus keeps its value.
        if (io_abort && (state_q != IDLE)) begin
            state_d  = IDLE;
            data_d   = data_q;
            en_d     = '0;
            idx_d    = '0;
            ready_d  = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            tmr_load = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            en_q    <= '0;
            idx_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            en_q    <= en_d;
            idx_q   <= idx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign io_in_ready   = ready_q;
    assign io_d_out      = data_q;
    assign io_configs_en = en_q;
    assign io_word_idx   = idx_q;
    assign io_busy       = busy_q;
    assign io_done       = done_q;

endmodule
